// File: rtl/div_monitor.sv
// Checks a divided clock sampled in the fast clk domain: measures period/high time, tracks lock, flags violations.
// Optional sticky error held until clear: define DIV_MONITOR_STICKY_ERR_EN.
module div_monitor #(
   parameter int DIV    = 6,
   parameter int LOCK_N = 4,
   parameter int CNT_W  = $clog2(2*DIV+1),
   parameter int EDGE_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_div_in,
   input  logic              clear,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              lock,
   output logic              err,
   output logic [EDGE_W-1:0] edge_cnt
);

   localparam int GOOD_W = $clog2(LOCK_N+1);
   localparam logic [CNT_W-1:0]  PH_MAX = CNT_W'(2*DIV);
   localparam logic [CNT_W-1:0]  PER_OK = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]  HI_OK  = CNT_W'(DIV/2);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

   typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

   state_t             state_q, state_d;
   logic               in_q, in_d;
   logic [CNT_W-1:0]   ph_q, ph_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic               lock_q, lock_d;
   logic               err_q, err_d;
   logic [EDGE_W-1:0]  edge_q, edge_d;
   logic               rise, fall, viol;

   always_comb begin
      rise     = clk_div_in & ~in_q;
      fall     = ~clk_div_in & in_q;
      in_d     = clk_div_in;
      state_d  = state_q;
      period_d = period_q;
      high_d   = high_q;
      good_d   = good_q;
      viol     = 1'b0;
      ph_d     = rise ? CNT_W'(1) : ((ph_q == PH_MAX) ? ph_q : ph_q + CNT_W'(1));
      edge_d   = rise ? edge_q + EDGE_W'(1) : edge_q;

      case (state_q)
         IDLE: if (rise) state_d = ARMED;
         ARMED, TRACK: begin
            if (fall) begin
               high_d = ph_q;
               if (ph_q != HI_OK) viol = 1'b1;
            end
            if (rise) begin
               period_d = ph_q;
               state_d  = TRACK;
               if (ph_q != PER_OK) viol = 1'b1;
               else if (good_q != GOOD_MAX) good_d = good_q + GOOD_W'(1);
            end else if (ph_q == PH_MAX) begin
               // divider stalled: drop back and wait for a fresh rise to re-arm
               viol    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (viol) good_d = '0;
      lock_d = (good_d == GOOD_MAX);
`ifdef DIV_MONITOR_STICKY_ERR_EN
      err_d = viol | (err_q & ~clear);
`else
      err_d = viol;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         in_q     <= 1'b0;
         ph_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         good_q   <= '0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         in_q     <= in_d;
         ph_q     <= ph_d;
         period_q <= period_d;
         high_q   <= high_d;
         good_q   <= good_d;
         lock_q   <= lock_d;
         err_q    <= err_d;
         edge_q   <= edge_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign lock      = lock_q;
   assign err       = err_q;
   assign edge_cnt  = edge_q;

endmodule

// File: tb/tb_div_monitor.sv
// Randomized bench for div_monitor with a cycle-index based reference model and literal pins.
module tb_div_monitor;
   localparam int DIV = 6, LOCK_N = 4, CNT_W = $clog2(2*DIV+1);

   logic clk = 1'b0, reset = 1'b1, clk_div_in = 1'b0, clear = 1'b0;
   logic [CNT_W-1:0] period, high_time, period4, high_time4;
   logic lock, err, lock4, err4;
   logic [15:0] edge_cnt;
   logic [3:0]  edge_cnt4;

   int compared = 0, mismatched = 0;
   bit rclr_en = 0;

   always #5 clk = ~clk;

   div_monitor #(.DIV(DIV), .LOCK_N(LOCK_N)) u_dut (
      .clk(clk), .reset(reset), .clk_div_in(clk_div_in), .clear(clear),
      .period(period), .high_time(high_time), .lock(lock), .err(err), .edge_cnt(edge_cnt));

   div_monitor #(.DIV(DIV), .LOCK_N(LOCK_N), .EDGE_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .clk_div_in(clk_div_in), .clear(clear),
      .period(period4), .high_time(high_time4), .lock(lock4), .err(err4), .edge_cnt(edge_cnt4));

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase is "cycles since last rise", synced means a rise has been seen since sync loss.
   int n = 0, ref_c = 0, run = 0, edges = 0;
   int exp_period = 0, exp_high = 0;
   bit prev = 0, synced = 0, exp_lock = 0, exp_err = 0, en = 0;

   always @(posedge clk) begin
      int ph; bit r, f, viol;
      if (reset) begin
         prev = 0; synced = 0; run = 0; edges = 0; ref_c = n + 1;
         exp_period = 0; exp_high = 0; exp_lock = 0; exp_err = 0; en = 1;
      end else begin
         r = clk_div_in && !prev;
         f = !clk_div_in && prev;
         ph = n - ref_c;
         if (ph > 2*DIV) ph = 2*DIV;
         viol = 0;
         if (f && synced) begin
            exp_high = ph;
            if (ph != DIV/2) viol = 1;
         end
         if (r) begin
            edges++;
            if (synced) begin
               exp_period = ph;
               if (ph != DIV) viol = 1;
               else if (run < LOCK_N) run++;
            end
            synced = 1;
            ref_c = n;
         end else if (synced && ph == 2*DIV) begin
            viol = 1;
            synced = 0;
         end
         if (viol) run = 0;
         exp_lock = (run == LOCK_N);
`ifdef DIV_MONITOR_STICKY_ERR_EN
         exp_err = viol || (exp_err && !clear);
`else
         exp_err = viol;
`endif
         prev = clk_div_in;
      end
      n++;
   end

   always @(negedge clk) begin
      if (en) begin
         chk("period", int'(period), exp_period);
         chk("high_time", int'(high_time), exp_high);
         chk("lock", int'(lock), int'(exp_lock));
         chk("err", int'(err), int'(exp_err));
         chk("edge_cnt", int'(edge_cnt), edges % 65536);
         chk("edge_cnt4", int'(edge_cnt4), edges % 16);
         chk("lock4", int'(lock4), int'(exp_lock));
      end
   end

   task automatic cyc(input bit v, input bit c);
      @(negedge clk);
      clk_div_in = v;
      clear = rclr_en ? ($urandom_range(0, 7) == 0) : c;
   endtask

   task automatic per(input int h, input int l);
      for (int i = 0; i < h; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < l; i++) cyc(1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      cyc(0, 0); cyc(0, 0);
      reset = 1'b0;
      chk("rst_period", int'(period), 0);
      chk("rst_lock", int'(lock), 0);
      chk("rst_edge", int'(edge_cnt), 0);
      chk("rst_err", int'(err), 0);

      // lock one cycle after the 5th rise
      for (int i = 0; i < 4; i++) per(3, 3);
      cyc(1, 0);
      chk("prelock", int'(lock), 0);
      cyc(1, 0);
      chk("lock5", int'(lock), 1);
      chk("period6", int'(period), 6);
      chk("high3", int'(high_time), 3);
      chk("edge5", int'(edge_cnt), 5);
      chk("err0", int'(err), 0);
      cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0);

      // one 8-cycle period with high time 4
      per(4, 4);
      chk("lock_drop", int'(lock), 0);
      for (int i = 0; i < 5; i++) per(3, 3);
      chk("relock", int'(lock), 1);

      // stall: timeout when phase reaches 12
      cyc(1, 0); cyc(1, 0); cyc(1, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0);
      chk("pre_timeout_err", int'(err), 0);
      cyc(0, 0);
      chk("timeout_err", int'(err), 1);
      chk("timeout_lock", int'(lock), 0);
      cyc(0, 0);
`ifdef DIV_MONITOR_STICKY_ERR_EN
      for (int i = 0; i < 20; i++) begin
         chk("sticky_hold", int'(err), 1);
         cyc(0, 0);
      end
      cyc(0, 1);
      cyc(0, 0);
      chk("sticky_clear", int'(err), 0);
`else
      chk("pulse_err", int'(err), 0);
`endif
      per(3, 3);
      chk("idle_rise_no_err", int'(err), 0);
      chk("idle_rise_period", int'(period), 6);

      // clear coinciding with a timeout
      cyc(1, 0); cyc(1, 0); cyc(1, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0);
      cyc(0, 1);
      cyc(0, 0);
      chk("clear_vs_viol", int'(err), 1);
      cyc(0, 1);
      cyc(0, 0);
      for (int i = 0; i < 5; i++) per(3, 3);
      chk("relock2", int'(lock), 1);

      // mid-run reset
      reset = 1'b1;
      cyc(0, 0);
      reset = 1'b0;
      chk("mrst_lock", int'(lock), 0);
      chk("mrst_edge", int'(edge_cnt), 0);
      chk("mrst_period", int'(period), 0);

      // 4-bit edge counter wrap: 15 -> 0 -> 1
      for (int i = 0; i < 15; i++) per(3, 3);
      chk("edge4_15", int'(edge_cnt4), 15);
      chk("relock3", int'(lock), 1);
      per(3, 3);
      chk("edge4_0", int'(edge_cnt4), 0);
      per(3, 3);
      chk("edge4_1", int'(edge_cnt4), 1);

      // randomized periods, stalls, clears and occasional resets
      rclr_en = 1;
      for (int k = 0; k < 300; k++) begin
         int h, l;
         h = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(1, 7));
         l = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(1, 7));
         if ($urandom_range(0, 29) == 0) l = int'($urandom_range(10, 16));
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            cyc(0, 0);
            reset = 1'b0;
         end
         per(h, l);
      end
      rclr_en = 0;
      cyc(0, 0); cyc(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/div_monitor.md
# div_monitor

Downstream checker for the divided clock produced by the even-ratio clock divider. It samples that divider's `clk_div` output as data in the fast `clk` domain and detects its rising and falling edges. It measures period and high time in `clk` cycles and declares lock after a run of correct periods. It flags ratio, duty and stall violations. It is used in silicon-test and bring-up to prove the divider runs at the configured ratio.

## Interface
Parameters:
- `DIV`, 6 — expected even division ratio; must match the divider instance; must be ≥ 2.
- `LOCK_N`, 4 — consecutive good periods required for lock; must be ≥ 1.
- `CNT_W`, `$clog2(2*DIV+1)` — width of the phase counter and of the measurement outputs.
- `EDGE_W`, 16 — width of the rising-edge counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  fast system clock; same clock that drives the divider.
- `reset`  in  1  synchronous, active-high reset.
- `clk_div_in`  in  1  divider output, sampled as data on `clk`.
- `clear`  in  1  clears the sticky error; has no effect unless the sticky-error macro is defined.
- `period`  out  CNT_W  last measured rise-to-rise distance, in `clk` cycles.
- `high_time`  out  CNT_W  last measured rise-to-fall distance, in `clk` cycles.
- `lock`  out  1  high after `LOCK_N` consecutive good periods.
- `err`  out  1  violation indicator.
- `edge_cnt`  out  EDGE_W  count of rising edges; wraps to 0.

## Operation
- `in_q` holds `clk_div_in` registered one cycle.
- `rise = clk_div_in & ~in_q`. `fall = ~clk_div_in & in_q`.
- Phase counter `ph`:
  - Loads 1 in the cycle after a rise.
  - Otherwise increments each cycle, saturating at `2*DIV`.
- In a rise cycle, the measured period is `ph`. In a fall cycle, the measured high time is `ph`. For DIV=6 this gives period=6, high_time=3.
- A period is good if it equals `DIV`. A high time is good if it equals `DIV/2`.
- State machine with states IDLE, ARMED and TRACK:
  - IDLE: on rise, go to ARMED. No checks are made and falls are ignored.
  - ARMED: on fall, check high time. On rise, load `period`, check it, and go to TRACK.
  - TRACK: on fall, check high time. On rise, load `period` and check it.
  - In ARMED or TRACK, if `ph == 2*DIV` and there is no rise in that cycle: timeout. Raise a violation, go to IDLE, set `lock` to 0, set the good count to 0.
- `high_time` and `period` registers are updated on every checked fall and rise, whether the value is good or bad.
- Good counter (saturating at `LOCK_N`):
  - Increments on each good rise-checked period.
  - `lock = (good == LOCK_N)`.
  - Any violation (bad period, bad high time, timeout) sets the good count and `lock` to 0.
- `edge_cnt` increments on every rise, in every state, and wraps.
- Simultaneous cases:
  - A rise in the same cycle that `ph == 2*DIV` is a bad period (period = 2*DIV). It is not a timeout, and the state goes to TRACK.
  - Rise and fall cannot coincide.
- If `clk_div_in` is 1 on the first cycle after reset, that cycle counts as a rise (IDLE→ARMED) because `in_q` resets to 0.

## Timing
- All outputs are registered. Reset values: `period`, `high_time`, `lock`, `err` and `edge_cnt` are all 0. Internal reset values: `in_q`=0, `ph`=0, good count=0, state IDLE.
- Latency: all outputs reflect an edge one cycle after the cycle in which `clk_div_in` first reads its new value. This covers measurements, `edge_cnt`, `lock` and `err`.
- Reset asserted mid-operation overrides everything. All outputs are 0 on the cycle after `reset` is sampled high.
- From reset release with a running divider (DIV=6, LOCK_N=4): `lock` rises one cycle after the 5th rise.

## Configuration
- `DIV_MONITOR_STICKY_ERR_EN`:
  - Defined: `err` sets on any violation and holds until `clear` is sampled high. It then drops on the next cycle.
  - Defined: if a violation and `clear` occur in the same cycle, `err` stays 1.
  - Not defined: `err` is a one-cycle pulse per violation and `clear` is ignored.

## Test plan
- Divider with DIV=6 attached, reset for 2 cycles, then run: `period`=6 and `high_time`=3 after the 2nd rise; `lock`=1 one cycle after the 5th rise; `err` stays 0; `edge_cnt` matches the number of rises.
- After lock, drive one period of 8 cycles with high time 4: `err` pulses (high_time 4 and period 8 are each violations); `lock` drops to 0; `lock` reasserts after 4 further good periods.
- After a rise, hold `clk_div_in` low: `err` fires when `ph` reaches 12; `lock`=0; state is IDLE. The next rise produces no error, and `period` is unchanged until the following rise.
- Build with `DIV_MONITOR_STICKY_ERR_EN`:
  - Force a violation: `err` stays 1 for 20 cycles.
  - Pulse `clear`: `err`=0 on the next cycle.
  - Assert `clear` in the same cycle as a new violation: `err` stays 1.
- Assert `reset` for 1 cycle while locked: the next cycle shows `lock`=0, `edge_cnt`=0, `period`=0; the block relocks normally afterwards.
- Set EDGE_W=4 and run 17 rises: `edge_cnt` goes 15→0→1.
